// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ==========================================================================
// mem_access_ctrl_if: CPU-side request/response bundle of mem_access_ctrl.
// Rev 1.0
// ==========================================================================
interface mem_access_ctrl_if;
  logic        req;
  logic        wr;
  logic        byte_op;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output req, wr, byte_op, addr, wdata,
    input  rdata, busy, done, err
  );

  modport slave (
    input  req, wr, byte_op, addr, wdata,
    output rdata, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ==========================================================================
// mem_access_ctrl: load/store sequencer for the RAM_B data block RAM; byte
// stores are read-modify-write, misaligned word accesses are rejected.
// Rev 1.0
// ==========================================================================
module mem_access_ctrl #(
  parameter int RAM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave cpu,
  output logic             ram_we,
  output logic [5:0]       ram_addr,
  output logic [31:0]      ram_din,
  input  logic [31:0]      ram_dout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    MERGE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Read spans RAM_LAT+1 edges: one for the RAM to sample ram_addr, RAM_LAT for douta.
  localparam logic [1:0] LAST_CNT = 2'(RAM_LAT);

  state_t      state;
  logic [1:0]  cnt;
  logic        lat_wr;
  logic        lat_byte;
  logic [1:0]  lat_lane;
  logic [7:0]  lat_bdata;

  function automatic logic [7:0] pick_lane(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      default: w[31:24] = b;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      cpu.rdata <= 32'd0;
      cpu.busy  <= 1'b0;
      cpu.done  <= 1'b0;
      cpu.err   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 6'd0;
      ram_din   <= 32'd0;
      lat_wr    <= 1'b0;
      lat_byte  <= 1'b0;
      lat_lane  <= 2'd0;
      lat_bdata <= 8'd0;
    end else begin
      cpu.done <= 1'b0;
      cpu.err  <= 1'b0;
      ram_we   <= 1'b0;
      case (state)
        // The done cycle accepts a new request so back-to-back accesses have no gap.
        IDLE, DONE: begin
          if (cpu.req) begin
            lat_wr    <= cpu.wr;
            lat_byte  <= cpu.byte_op;
            lat_lane  <= cpu.addr[1:0];
            lat_bdata <= cpu.wdata[7:0];
            ram_addr  <= cpu.addr[7:2];
            cnt       <= 2'd0;
            if (!cpu.byte_op && (cpu.addr[1:0] != 2'd0)) begin
              state    <= DONE;
              cpu.busy <= 1'b0;
              cpu.done <= 1'b1;
              cpu.err  <= 1'b1;
            end else if (cpu.wr && !cpu.byte_op) begin
              state    <= WR;
              cpu.busy <= 1'b1;
              ram_we   <= 1'b1;
              ram_din  <= cpu.wdata;
            end else begin
              state    <= RD;
              cpu.busy <= 1'b1;
            end
          end else begin
            state    <= IDLE;
            cpu.busy <= 1'b0;
          end
        end
        WR, MERGE: begin
          state    <= DONE;
          cpu.busy <= 1'b0;
          cpu.done <= 1'b1;
        end
        RD: begin
          if (cnt == LAST_CNT) begin
            if (lat_wr) begin
              state   <= MERGE;
              ram_we  <= 1'b1;
              ram_din <= merge_lane(ram_dout, lat_lane, lat_bdata);
            end else begin
              state     <= DONE;
              cpu.busy  <= 1'b0;
              cpu.done  <= 1'b1;
              cpu.rdata <= lat_byte ? {24'd0, pick_lane(ram_dout, lat_lane)} : ram_dout;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: begin
          state    <= IDLE;
          cpu.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
